// File: rtl/tt_mux_seq_if.sv
// Row-mux bus bundle: user-module array, spine in/out, address strap and status.
interface tt_mux_seq_if #(
   parameter int unsigned N_UM = 16,
   parameter int unsigned N_IO = 8,
   parameter int unsigned N_O  = 8,
   parameter int unsigned N_I  = 10
);
   localparam int unsigned U_OW = N_O + 2 * N_IO;
   localparam int unsigned U_IW = N_I + N_IO;

   logic [U_OW*N_UM-1:0] um_ow;
   logic [U_IW*N_UM-1:0] um_iw;
   logic [N_UM-1:0]      um_ena;
   logic [N_UM-1:0]      um_pg_vdd;
   logic [N_UM-1:0]      um_k_zero;
   logic [U_OW+1:0]      spine_ow;
   logic [U_IW+12:0]     spine_iw;
   logic [4:0]           addr;
   logic                 seq_busy;
   logic                 k_zero;
   logic                 k_one;

   // Spine / controller side.
   modport master (
      output um_ow, spine_iw, addr,
      input  um_iw, um_ena, um_pg_vdd, um_k_zero, spine_ow, seq_busy, k_zero, k_one
   );

   // Row multiplexer side.
   modport slave (
      input  um_ow, spine_iw, addr,
      output um_iw, um_ena, um_pg_vdd, um_k_zero, spine_ow, seq_busy, k_zero, k_one
   );
endinterface

// File: rtl/tt_mux_seq.sv
// Row multiplexer with power sequencing: at most one user module is powered,
// enabled and connected to the spine at a time.
module tt_mux_seq #(
   parameter int unsigned N_UM      = 16,
   parameter int unsigned N_IO      = 8,
   parameter int unsigned N_O       = 8,
   parameter int unsigned N_I       = 10,
   parameter int unsigned PG_DELAY  = 16,
   parameter int unsigned ISO_DELAY = 2
) (
   input logic         clk,
   input logic         rst_n,
   tt_mux_seq_if.slave bus
);
   localparam int unsigned U_OW    = N_O + 2 * N_IO;
   localparam int unsigned U_IW    = N_I + N_IO;
   localparam int unsigned MAX_DLY = (PG_DELAY > ISO_DELAY) ? PG_DELAY : ISO_DELAY;
   localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_PWR_UP,
      ST_ACTIVE,
      ST_ISOLATE,
      ST_PWR_DN
   } state_t;

   state_t           state, state_nxt;
   logic [4:0]       cur, cur_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [U_IW-1:0]  usr_q;
   logic [9:0]       sel_q;
   logic             ena_q;

   logic [4:0]       tgt;
   logic             req_valid;

   logic [N_UM-1:0]      ena_nxt, ena_r;
   logic [N_UM-1:0]      pg_nxt, pg_r;
   logic [U_IW*N_UM-1:0] iw_nxt, iw_r;
   logic [U_OW-1:0]      usr_out_nxt, usr_out_r;
   logic                 busy_nxt, busy_r;

   // Guard bits carry no information.
   logic unused_guards;
   assign unused_guards = bus.spine_iw[0] ^ bus.spine_iw[U_IW+12];

   // Request decode from the registered spine word; out-of-range targets are invalid.
   assign tgt       = sel_q[4:0];
   assign req_valid = ena_q && (sel_q[9:5] == bus.addr) && ({1'b0, tgt} < 6'(N_UM));

   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      cnt_nxt   = cnt;
      case (state)
         ST_OFF: begin
            if (req_valid) begin
               state_nxt = ST_PWR_UP;
               cur_nxt   = tgt;
               cnt_nxt   = CNT_W'(PG_DELAY);
            end
         end
         ST_PWR_UP: begin
            // An abort wins over completion on the same cycle.
            if (!req_valid || (tgt != cur)) begin
               state_nxt = ST_ISOLATE;
               cnt_nxt   = CNT_W'(ISO_DELAY);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
               if (cnt <= CNT_W'(1)) state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (!req_valid || (tgt != cur)) begin
               state_nxt = ST_ISOLATE;
               cnt_nxt   = CNT_W'(ISO_DELAY);
            end
         end
         ST_ISOLATE: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) state_nxt = ST_PWR_DN;
         end
         ST_PWR_DN: begin
            state_nxt = ST_OFF;
         end
         default: begin
            state_nxt = ST_OFF;
         end
      endcase
   end

   // Output values for the state being entered, so every output comes straight from a flop.
   always_comb begin
      ena_nxt     = '0;
      pg_nxt      = '1;
      iw_nxt      = '0;
      usr_out_nxt = '0;
      busy_nxt    = !((state_nxt == ST_OFF) || (state_nxt == ST_ACTIVE));
      for (int i = 0; i < int'(N_UM); i++) begin
         if (5'(i) == cur_nxt) begin
            case (state_nxt)
               ST_PWR_UP, ST_ISOLATE: begin
                  pg_nxt[i] = 1'b0;
               end
               ST_ACTIVE: begin
                  pg_nxt[i]                = 1'b0;
                  ena_nxt[i]               = 1'b1;
                  iw_nxt[U_IW*i +: U_IW]   = usr_q;
                  usr_out_nxt              = bus.um_ow[U_OW*i +: U_OW];
               end
               default: begin
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_OFF;
         cur       <= '0;
         cnt       <= '0;
         usr_q     <= '0;
         sel_q     <= '0;
         ena_q     <= 1'b0;
         ena_r     <= '0;
         pg_r      <= '1;
         iw_r      <= '0;
         usr_out_r <= '0;
         busy_r    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cur       <= cur_nxt;
         cnt       <= cnt_nxt;
         usr_q     <= bus.spine_iw[U_IW+11:12];
         sel_q     <= bus.spine_iw[11:2];
         ena_q     <= bus.spine_iw[1];
         ena_r     <= ena_nxt;
         pg_r      <= pg_nxt;
         iw_r      <= iw_nxt;
         usr_out_r <= usr_out_nxt;
         busy_r    <= busy_nxt;
      end
   end

   assign bus.um_ena    = ena_r;
   assign bus.um_pg_vdd = pg_r;
   assign bus.um_iw     = iw_r;
   assign bus.spine_ow  = {1'b0, usr_out_r, 1'b0};
   assign bus.seq_busy  = busy_r;
   assign bus.um_k_zero = '0;
   assign bus.k_zero    = 1'b0;
   assign bus.k_one     = 1'b1;
endmodule

// File: tb/tb_tt_mux_seq.sv
// Bench for tt_mux_seq: timeline model of the power sequence checked every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_tt_mux_seq;
   localparam int unsigned N_UM      = 16;
   localparam int unsigned N_IO      = 8;
   localparam int unsigned N_O       = 8;
   localparam int unsigned N_I       = 10;
   localparam int unsigned PG_DELAY  = 4;
   localparam int unsigned ISO_DELAY = 2;
   localparam int unsigned U_OW      = N_O + 2 * N_IO;
   localparam int unsigned U_IW      = N_I + N_IO;
   localparam int unsigned CW        = U_IW * N_UM;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   tt_mux_seq_if #(.N_UM(N_UM), .N_IO(N_IO), .N_O(N_O), .N_I(N_I)) bus ();

   tt_mux_seq #(
      .N_UM(N_UM), .N_IO(N_IO), .N_O(N_O), .N_I(N_I),
      .PG_DELAY(PG_DELAY), .ISO_DELAY(ISO_DELAY)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int hi, input int lo, input bit en, input logic [U_IW-1:0] usr);
      bus.spine_iw = {1'b0, usr, 5'(hi), 5'(lo), en, 1'b0};
   endtask

   // Timeline model: m_up counts cycles since power was applied, m_down counts
   // isolation cycles, m_pd marks the single power-down cycle.
   int                   m_mod, m_up, m_down;
   bit                   m_pd;
   bit                   r_v;
   int                   r_t;
   logic [U_IW-1:0]      r_usr;
   logic [N_UM-1:0]      e_ena, e_pg;
   logic [CW-1:0]        e_iw;
   logic [U_OW-1:0]      e_usr;
   bit                   e_busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mod = -1; m_up = 0; m_down = -1; m_pd = 0;
         r_v = 0; r_t = 0; r_usr = '0;
         e_ena = '0; e_pg = '1; e_iw = '0; e_usr = '0; e_busy = 0;
      end else begin
         bit active;
         if (m_pd) begin
            m_pd = 0; m_mod = -1;
         end else if (m_mod < 0) begin
            if (r_v) begin m_mod = r_t; m_up = 0; m_down = -1; end
         end else if (m_down >= 0) begin
            m_down++;
            if (m_down == int'(ISO_DELAY)) m_pd = 1;
         end else if (!r_v || r_t != m_mod) begin
            m_down = 0;
         end else if (m_up < int'(PG_DELAY)) begin
            m_up++;
         end
         active = (m_mod >= 0) && !m_pd && (m_down < 0) && (m_up == int'(PG_DELAY));
         e_ena = '0; e_pg = '1; e_iw = '0; e_usr = '0;
         if (m_mod >= 0 && !m_pd) e_pg[m_mod] = 1'b0;
         if (active) begin
            e_ena[m_mod] = 1'b1;
            e_iw[m_mod*U_IW +: U_IW] = r_usr;
            e_usr = bus.um_ow[m_mod*U_OW +: U_OW];
         end
         e_busy = (m_mod >= 0) && !active;
         r_v   = bus.spine_iw[1] && (int'(bus.spine_iw[11:7]) == int'(bus.addr))
                 && (int'(bus.spine_iw[6:2]) < int'(N_UM));
         r_t   = int'(bus.spine_iw[6:2]);
         r_usr = bus.spine_iw[U_IW+11:12];
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("ena", CW'(bus.um_ena), CW'(e_ena));
         check("pg_vdd", CW'(bus.um_pg_vdd), CW'(e_pg));
         check("iw", bus.um_iw, e_iw);
         check("spine_ow", CW'(bus.spine_ow), CW'({1'b0, e_usr, 1'b0}));
         check("busy", CW'(bus.seq_busy), CW'(e_busy));
         check("consts", CW'({bus.k_one, bus.k_zero, bus.um_k_zero}), CW'({1'b1, 1'b0, 16'h0}));
         check("one_powered", CW'($countones(~bus.um_pg_vdd) <= 1), CW'(1));
      end
   end

   task automatic chk_idle(input string tag);
      check({tag, "_ena"}, CW'(bus.um_ena), CW'(16'h0000));
      check({tag, "_pg"}, CW'(bus.um_pg_vdd), CW'(16'hFFFF));
      check({tag, "_iw"}, bus.um_iw, CW'(0));
      check({tag, "_busy"}, CW'(bus.seq_busy), CW'(0));
      check({tag, "_spine"}, CW'(bus.spine_ow), CW'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      bus.um_ow = '0;
      bus.spine_iw = '0;
      bus.addr = 5'd3;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Power-up of module 5.
      set_req(3, 5, 1'b1, '0);
      @(negedge clk);
      check("pu_pg_before", CW'(bus.um_pg_vdd), CW'(16'hFFFF));
      @(negedge clk);
      check("pu_pg_on", CW'(bus.um_pg_vdd), CW'(16'hFFDF));
      check("pu_busy", CW'(bus.seq_busy), CW'(1));
      repeat (3) @(negedge clk);
      check("pu_ena_early", CW'(bus.um_ena), CW'(16'h0000));
      check("pu_busy_late", CW'(bus.seq_busy), CW'(1));
      @(negedge clk);
      check("pu_ena_on", CW'(bus.um_ena), CW'(16'h0020));
      check("pu_busy_done", CW'(bus.seq_busy), CW'(0));

      // Data path in ACTIVE.
      set_req(3, 5, 1'b1, 18'h2A5);
      bus.um_ow[5*U_OW +: U_OW] = 24'h001234;
      @(negedge clk);
      check("dp_spine", CW'(bus.spine_ow), CW'({1'b0, 24'h001234, 1'b0}));
      check("dp_iw_early", bus.um_iw, CW'(0));
      @(negedge clk);
      check("dp_iw", bus.um_iw, CW'(18'h2A5) << (U_IW * 5));

      // Switch target to module 9.
      set_req(3, 9, 1'b1, 18'h2A5);
      @(negedge clk);
      check("sw_ena_hold", CW'(bus.um_ena), CW'(16'h0020));
      @(negedge clk);
      check("sw_ena_off", CW'(bus.um_ena), CW'(16'h0000));
      check("sw_iso_pg", CW'(bus.um_pg_vdd), CW'(16'hFFDF));
      check("sw_iso_iw", bus.um_iw, CW'(0));
      check("sw_iso_spine", CW'(bus.spine_ow), CW'(0));
      @(negedge clk);
      check("sw_iso2_pg", CW'(bus.um_pg_vdd), CW'(16'hFFDF));
      @(negedge clk);
      check("sw_pdn_pg", CW'(bus.um_pg_vdd), CW'(16'hFFFF));
      check("sw_pdn_busy", CW'(bus.seq_busy), CW'(1));
      @(negedge clk);
      check("sw_off_busy", CW'(bus.seq_busy), CW'(0));
      @(negedge clk);
      check("sw_new_pg", CW'(bus.um_pg_vdd), CW'(16'hFDFF));
      repeat (4) @(negedge clk);
      check("sw_new_ena", CW'(bus.um_ena), CW'(16'h0200));

      // Release, then abort a power-up at count 2.
      set_req(3, 9, 1'b0, '0);
      repeat (5) @(negedge clk);
      chk_idle("rel");
      set_req(3, 5, 1'b1, '0);
      repeat (4) @(negedge clk);
      check("ab_pg_cnt2", CW'(bus.um_pg_vdd), CW'(16'hFFDF));
      set_req(3, 5, 1'b0, '0);
      @(negedge clk);
      check("ab_pg_1", CW'(bus.um_pg_vdd), CW'(16'hFFDF));
      @(negedge clk);
      check("ab_pg_2", CW'(bus.um_pg_vdd), CW'(16'hFFDF));
      check("ab_ena_2", CW'(bus.um_ena), CW'(16'h0000));
      @(negedge clk);
      check("ab_pg_3", CW'(bus.um_pg_vdd), CW'(16'hFFDF));
      @(negedge clk);
      check("ab_pg_off", CW'(bus.um_pg_vdd), CW'(16'hFFFF));
      check("ab_ena_never", CW'(bus.um_ena), CW'(16'h0000));
      @(negedge clk);
      chk_idle("ab_done");

      // Address miss and out-of-range targets.
      set_req(4, 5, 1'b1, '0);
      repeat (4) @(negedge clk);
      chk_idle("miss_addr");
      set_req(3, 20, 1'b1, '0);
      repeat (4) @(negedge clk);
      chk_idle("miss_20");
      set_req(3, 16, 1'b1, '0);
      repeat (4) @(negedge clk);
      chk_idle("miss_16");

      // Highest legal target.
      bus.um_ow[15*U_OW +: U_OW] = 24'hABCDEF;
      set_req(3, 15, 1'b1, '0);
      repeat (2) @(negedge clk);
      check("top_pg", CW'(bus.um_pg_vdd), CW'(16'h7FFF));
      repeat (4) @(negedge clk);
      check("top_ena", CW'(bus.um_ena), CW'(16'h8000));
      check("top_spine", CW'(bus.spine_ow), CW'({1'b0, 24'hABCDEF, 1'b0}));

      // Asynchronous reset pulse between clock edges.
      #1 rst_n = 1'b0;
      #1 chk_idle("async");
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_pg1", CW'(bus.um_pg_vdd), CW'(16'hFFFF));
      @(negedge clk);
      check("post_rst_pg2", CW'(bus.um_pg_vdd), CW'(16'h7FFF));

      set_req(0, 0, 1'b0, '0);
      repeat (10) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
